sha2_k_sequencer: RTL

- Parametrised round-constant source for the SHA-2 compression cores; successor to the fixed 64-entry SHA-256 K table.
- WORD_W selects the family: SHA-256 (32-bit, 64 rounds, FIPS 180-4 §4.2.2) or SHA-512 (64-bit, 80 rounds, FIPS 180-4 §4.2.3).
- Streams K_0..K_{R-1} autonomously over a valid/ready handshake, with round index and last flag.
- Also offers a registered random-access read port while idle.

---
 rtl/sha2_k_sequencer.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/sha2_k_sequencer.sv
// SHA-2 round-constant sequencer: streams K_0..K_{R-1} over valid/ready and
// serves registered random-access reads while idle. WORD_W picks SHA-256 or SHA-512.
module sha2_k_sequencer #(
  parameter int WORD_W = 32,
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              k_ready,
  output logic              k_valid,
  output logic [WORD_W-1:0] k_data,
  output logic [ADDR_W-1:0] k_round,
  output logic              k_last,
  output logic              busy,
  output logic              done,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid
);

  localparam int ROUNDS = (WORD_W == 64) ? 80 : 64;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(ROUNDS - 1);

  if (WORD_W != 32 && WORD_W != 64) begin : g_bad_word_w
    $error("sha2_k_sequencer: WORD_W must be 32 or 64");
  end
  if (ADDR_W < $clog2(ROUNDS)) begin : g_bad_addr_w
    $error("sha2_k_sequencer: ADDR_W too narrow for ROUNDS");
  end

  logic [ADDR_W-1:0] rom_addr;
  logic [WORD_W-1:0] rom_data;

  // Out-of-range addresses read as zero so random access never aliases.
  if (WORD_W == 64) begin : g_k512
    localparam logic [63:0] K [80] = '{
      64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
      64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
      64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
      64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
      64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
      64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
      64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
      64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
      64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
      64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
      64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
      64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
      64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
      64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
      64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
      64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
      64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
      64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
      64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
      64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
    };
    always_comb rom_data = (rom_addr <= LAST) ? K[rom_addr[6:0]] : '0;
  end else begin : g_k256
    localparam logic [31:0] K [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    always_comb rom_data = (rom_addr <= LAST) ? K[rom_addr[5:0]] : '0;
  end

  typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_t;
  state_t state, state_nxt;

  logic [WORD_W-1:0] k_data_nxt;
  logic [ADDR_W-1:0] k_round_nxt, round_inc;
  logic              k_valid_nxt, k_last_nxt, busy_nxt, done_nxt, rd_valid_nxt;

  assign round_inc = k_round + 1'b1;

  always_comb begin
    state_nxt    = state;
    k_data_nxt   = k_data;
    k_round_nxt  = k_round;
    k_valid_nxt  = k_valid;
    k_last_nxt   = k_last;
    busy_nxt     = busy;
    done_nxt     = 1'b0;
    rd_valid_nxt = 1'b0;
    rom_addr     = round_inc;
    if (abort) begin
      state_nxt   = IDLE;
      k_round_nxt = '0;
      k_valid_nxt = 1'b0;
      k_last_nxt  = 1'b0;
      busy_nxt    = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            rom_addr    = '0;
            state_nxt   = STREAM;
            k_data_nxt  = rom_data;
            k_round_nxt = '0;
            k_valid_nxt = 1'b1;
            k_last_nxt  = (LAST == '0);
            busy_nxt    = 1'b1;
          end else if (rd_en) begin
            rom_addr     = rd_addr;
            k_data_nxt   = rom_data;
            k_round_nxt  = rd_addr;
            rd_valid_nxt = 1'b1;
          end
        end
        STREAM: begin
          if (k_ready) begin
            if (k_last) begin
              state_nxt   = IDLE;
              k_valid_nxt = 1'b0;
              k_last_nxt  = 1'b0;
              busy_nxt    = 1'b0;
              done_nxt    = 1'b1;
            end else begin
              k_data_nxt  = rom_data;
              k_round_nxt = round_inc;
              k_last_nxt  = (round_inc == LAST);
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      k_data   <= '0;
      k_round  <= '0;
      k_valid  <= 1'b0;
      k_last   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rd_valid <= 1'b0;
    end else begin
      state    <= state_nxt;
      k_data   <= k_data_nxt;
      k_round  <= k_round_nxt;
      k_valid  <= k_valid_nxt;
      k_last   <= k_last_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      rd_valid <= rd_valid_nxt;
    end
  end

endmodule
